// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Purpose : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//           valid/ready producers, with bursts of up to BURST_LEN beats.
// Rev     : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [15:0]                   xfer_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0]      c_last_beat = 8'(BURST_LEN - 1);
  localparam logic [ID_W-1:0] c_last_id   = ID_W'(NUM_REQ - 1);

  state_t                r_state;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_last_id;
  logic [7:0]            r_beat_cnt;
  logic [15:0]           r_xfer_count;

  state_t                w_state_nxt;
  logic [ID_W-1:0]       w_grant_nxt;
  logic [ID_W-1:0]       w_last_nxt;
  logic [7:0]            w_beat_nxt;
  logic [15:0]           w_count_nxt;

  logic [DATA_WIDTH-1:0] w_lane [NUM_REQ];
  logic                  w_any_valid;
  logic                  w_gnt_valid;
  logic                  w_xfer;
  logic                  w_release;
  logic [ID_W-1:0]       w_pick_base;
  logic [ID_W-1:0]       w_pick;

  // Scan offsets from NUM_REQ down to 1 so the nearest valid index after
  // base wins; offset NUM_REQ is base itself, the last-resort candidate.
  function automatic logic [ID_W-1:0] f_rr_pick(input logic [ID_W-1:0] base,
                                                input logic [NUM_REQ-1:0] vld);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = base;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (vld[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_lane[g]    = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[g] = busy && (r_grant_id == ID_W'(g)) && !fifo_full;
  end

  assign busy         = (r_state == ST_GRANT);
  assign grant_id     = r_grant_id;
  assign xfer_count   = r_xfer_count;
  assign fifo_data_in = w_lane[r_grant_id];

  assign w_any_valid = |req_valid;
  assign w_gnt_valid = req_valid[r_grant_id];
  assign w_xfer      = busy && w_gnt_valid && !fifo_full;
  assign fifo_wr_en  = w_xfer;
  assign w_release   = busy && (!w_gnt_valid || (w_xfer && (r_beat_cnt == c_last_beat)));

  // On release the grant holder becomes last_id, so the re-pick scans from it.
  assign w_pick_base = busy ? r_grant_id : r_last_id;
  assign w_pick      = f_rr_pick(w_pick_base, req_valid);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_id;
    w_beat_nxt  = r_beat_cnt;
    w_count_nxt = r_xfer_count;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_xfer) begin
          w_beat_nxt  = r_beat_cnt + 8'd1;
          w_count_nxt = r_xfer_count + 16'd1;
        end
        if (w_release) begin
          w_last_nxt = r_grant_id;
          w_beat_nxt = '0;
          if (w_any_valid) w_grant_nxt = w_pick;
          else             w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_id    <= c_last_id;
      r_beat_cnt   <= '0;
      r_xfer_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_id    <= w_last_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_xfer_count <= w_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Purpose : Scoreboard bench for fifo_wr_arbiter against a rule-level model.
// Rev     : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data_in;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [15:0]      xfer_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy),
    .xfer_count(xfer_count)
  );

  typedef struct packed {
    logic          busy;
    logic          wr;
    logic          chk_data;
    logic [IW-1:0] gid;
    logic [DW-1:0] data;
    logic [NR-1:0] rdy;
    logic [15:0]   cnt;
  } exp_t;

  typedef logic [DW-1:0] byte_q_t[$];

  exp_t    exp_q[$];
  byte_q_t pq[NR];
  int      log_id[$];
  int      log_data[$];
  bit      log_en = 1'b0;
  int      checks = 0;
  int      errors = 0;

  // Reference state: who owns the port, beats taken in this burst, last owner.
  bit m_busy;
  int m_gid, m_last, m_beats, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic int pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return last;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gid = 0; m_last = NR - 1; m_beats = 0; m_cnt = 0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) pq[i].delete();
    log_id.delete();
    log_data.delete();
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_wr", 32'(fifo_wr_en), 32'd0);
      e = '0;
      e.chk_data = 1'b1;
      e.data = req_data[DW-1:0];
      exp_q.push_back(e);
    end
    model_reset();
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic cycle(input logic [NR-1:0] want, input logic full);
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
    exp_t             e;
    bit               xfer;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v[i] = want[i] && (pq[i].size() > 0);
      d[i*DW +: DW] = v[i] ? pq[i][0] : DW'($urandom);
    end
    req_valid = v;
    req_data  = d;
    fifo_full = full;
    e = '0;
    e.busy = m_busy;
    e.gid  = IW'(m_gid);
    e.cnt  = 16'(m_cnt);
    if (m_busy) begin
      xfer = v[m_gid] && !full;
      if (!full) e.rdy[m_gid] = 1'b1;
      e.wr = xfer;
      e.chk_data = xfer;
      e.data = d[m_gid*DW +: DW];
      if (xfer) begin
        void'(pq[m_gid].pop_front());
        m_beats++;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (!v[m_gid] || (xfer && m_beats == BL)) begin
        m_last  = m_gid;
        m_beats = 0;
        if (v != '0) m_gid = pick(m_last, v);
        else         m_busy = 1'b0;
      end
    end else if (v != '0) begin
      m_gid   = pick(m_last, v);
      m_beats = 0;
      m_busy  = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic sync();
    @(negedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("wr_en", 32'(fifo_wr_en), 32'(e.wr));
        chk("grant_id", 32'(grant_id), 32'(e.gid));
        chk("req_ready", 32'(req_ready), 32'(e.rdy));
        chk("xfer_count", 32'(xfer_count), 32'(e.cnt));
        if (e.chk_data) chk("data_in", 32'(fifo_data_in), 32'(e.data));
        if (log_en && fifo_wr_en) begin
          log_id.push_back(int'(grant_id));
          log_data.push_back(int'(fifo_data_in));
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();

    // Single producer, re-granted back to back.
    reset_cycles(2);
    clear_queues();
    for (int k = 0; k < 8; k++) pq[0].push_back(DW'(8'h10 + k));
    log_en = 1'b1;
    repeat (11) cycle(4'b0001, 1'b0);
    sync();
    chk("t1_writes", 32'(log_id.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_data.size(); k++)
      chk("t1_data", 32'(log_data[k]), 32'(8'h10 + k));
    chk("t1_count", 32'(xfer_count), 32'd8);
    log_en = 1'b0;

    // All four valid: 32 beats in 33 cycles, rotation every 4.
    reset_cycles(1);
    clear_queues();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(DW'(i * 16 + k));
    log_en = 1'b1;
    repeat (33) cycle(4'b1111, 1'b0);
    sync();
    chk("t2_writes", 32'(log_id.size()), 32'd32);
    for (int k = 0; k < 32 && k < log_id.size(); k++) begin
      chk("t2_order", 32'(log_id[k]), 32'(((k / 4) % 4)));
      chk("t2_data", 32'(log_data[k]), 32'(((k / 4) % 4) * 16 + (k / 16) * 4 + (k % 4)));
    end
    log_en = 1'b0;

    // Backpressure in the middle of producer 2's burst.
    reset_cycles(1);
    clear_queues();
    for (int k = 0; k < 4; k++) pq[2].push_back(DW'(8'h20 + k));
    repeat (3) cycle(4'b0100, 1'b0);
    repeat (3) cycle(4'b0100, 1'b1);
    repeat (4) cycle(4'b0100, 1'b0);
    sync();
    chk("t3_drained", 32'(pq[2].size()), 32'd0);

    // Early release from producer 1 to producer 3.
    reset_cycles(1);
    clear_queues();
    for (int k = 0; k < 2; k++) pq[1].push_back(DW'(8'h30 + k));
    for (int k = 0; k < 4; k++) pq[3].push_back(DW'(8'h40 + k));
    log_en = 1'b1;
    repeat (9) cycle(4'b1010, 1'b0);
    sync();
    chk("t4_writes", 32'(log_id.size()), 32'd6);
    for (int k = 0; k < 6 && k < log_id.size(); k++)
      chk("t4_order", 32'(log_id[k]), (k < 2) ? 32'd1 : 32'd3);
    log_en = 1'b0;

    // Randomized traffic with random backpressure.
    clear_queues();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 2) == 0 && pq[i].size() < 12) pq[i].push_back(DW'($urandom));
      cycle(NR'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Reset during a producer 3 burst, then 0 beats 3 in arbitration.
    reset_cycles(1);
    clear_queues();
    for (int k = 0; k < 4; k++) pq[3].push_back(DW'(8'h50 + k));
    repeat (3) cycle(4'b1000, 1'b0);
    reset_cycles(1);
    for (int k = 0; k < 2; k++) pq[0].push_back(DW'(8'h60 + k));
    log_en = 1'b1;
    repeat (4) cycle(4'b1001, 1'b0);
    sync();
    chk("t6_first_id", (log_id.size() > 0) ? 32'(log_id[0]) : 32'hFFFF_FFFF, 32'd0);
    log_en = 1'b0;

    // Counter wrap after 65536 beats, then idle.
    reset_cycles(1);
    clear_queues();
    for (int k = 0; k < 65536; k++) pq[1].push_back(DW'($urandom));
    repeat (65540) cycle(4'b0010, 1'b0);
    sync();
    chk("t7_wrap", 32'(xfer_count), 32'd0);
    chk("t7_idle", 32'(busy), 32'd0);

    sync();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a synchronous FIFO among NUM_REQ independent producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_LEN beats and drives the FIFO's wr_en/data_in. It honours the FIFO's full flag as backpressure and keeps a running count of accepted beats for debug.

## Interface
- DATA_WIDTH, 8, width of each producer's data and of the FIFO data port
- NUM_REQ, 4, number of producers (2..16)
- BURST_LEN, 4, maximum beats per grant before forced rotation (1..255)
- ID_W, $clog2(NUM_REQ), width of grant_id

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  producer i has a beat on its data lane
- req_data  in  NUM_REQ*DATA_WIDTH  producer i data on bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot or zero; beat from producer i accepted when req_valid[i] & req_ready[i]
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr_en  out  1  write strobe to FIFO
- fifo_data_in  out  DATA_WIDTH  write data to FIFO
- grant_id  out  ID_W  index of producer currently granted
- busy  out  1  high while in GRANT
- xfer_count  out  16  total accepted beats since reset, wraps 0xFFFF->0

## Operation
- States: IDLE, GRANT. Registered: state, grant_id, last_id, beat_cnt (8 bit), xfer_count.
- Round-robin pick: first i with req_valid[i]=1 scanning last_id+1, last_id+2, ... mod NUM_REQ, including last_id itself as the final candidate.
- IDLE: req_ready=0, fifo_wr_en=0. If any req_valid, load grant_id=pick, beat_cnt=0, go GRANT.
- GRANT: req_ready[grant_id] = !fifo_full; all other bits 0.
- xfer = req_valid[grant_id] & !fifo_full.
- fifo_wr_en = xfer; fifo_data_in = req_data lane grant_id (combinational mux, valid whenever in GRANT).
- On xfer: beat_cnt+1, xfer_count+1.
- Release condition in GRANT is any of:
  - xfer with beat_cnt == BURST_LEN-1
  - req_valid[grant_id]==0, i.e. the producer went idle
- On release, last_id=grant_id. If any req_valid is set, re-pick from the new last_id in the same cycle, load grant_id, beat_cnt=0, stay GRANT (zero-bubble handover). Otherwise go IDLE.
- The release-cycle pick uses current-cycle req_valid. The releasing producer is eligible only if no other producer is valid.
- fifo_full in GRANT: stall. No transfer, beat_cnt holds, grant holds, no release while req_valid[grant_id] stays high.
- Data from a producer is never reordered or dropped; the arbiter never asserts fifo_wr_en while fifo_full=1.

## Timing
- Reset (asynchronous): state=IDLE, grant_id=0, last_id=NUM_REQ-1 (so producer 0 wins the first arbitration), beat_cnt=0, xfer_count=0.
- Outputs during reset: req_ready=0, fifo_wr_en=0, busy=0, fifo_data_in=lane 0.
- Arbitration latency from IDLE: req_valid seen at edge N gives grant_id/busy valid after edge N+1. First beat is accepted in the cycle following edge N+1.
- Handover latency between bursts: 0 cycles. The last beat of producer A and the first beat of producer B occur on consecutive cycles.
- Peak throughput: one beat per cycle while fifo_full=0.
- fifo_full is sampled combinationally. It gates req_ready and fifo_wr_en in the same cycle.
- BURST_LEN=1: rotation after every beat.
- Reset asserted mid-burst: all state clears immediately and the in-flight beat is not written. Producers must re-present.

## Test plan
- Single producer: after reset, req_valid=4'b0001 held with data 0x10..0x17 and fifo_full=0, BURST_LEN=4. Required: grant_id=0 one cycle later, then 8 consecutive writes 0x10..0x17. Producer 0 is re-granted after each burst with no bubble. xfer_count=8.
- All four producers valid continuously, each sending 8 beats, BURST_LEN=4. Required: FIFO write order is 4 beats from 0, 4 from 1, 4 from 2, 4 from 3, then 4 more from each in the same order. Total 32 writes in 33 cycles from first req_valid. busy stays high throughout.
- Backpressure: producer 2 mid-burst after beat 2, fifo_full=1 for 3 cycles. Required: fifo_wr_en=0 and req_ready=0 for those 3 cycles, grant_id stays 2, beat_cnt holds. Beats 3-4 complete after fifo_full drops.
- Early release: producer 1 drops req_valid after 2 beats while producer 3 is valid. Required: grant moves to 3 on the next cycle, and beat_cnt restarts at 0.
- Wrap and idle: xfer_count preloaded by sending 65536 beats. Required: count reads 0 after wrap. All req_valid low: state returns to IDLE and busy=0 one cycle after the last beat.
- Reset mid-burst: assert rst during a producer 3 burst. Required: outputs go to reset values asynchronously. After release, producer 0 wins when producers 0 and 3 are both valid.
